// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, operand width, in-flight
// write limit and the operand-fetch output record.
package cpu_pkg;
  localparam int XLEN         = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int MAX_INFLIGHT = 3;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  // Operands and destination latched for the execute stage.
  typedef struct packed {
    logic [XLEN-1:0] op0;
    logic [XLEN-1:0] op1;
    reg_idx_t        rd;
    logic            rd_we;
  } fetch_out_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters.
// Ports:
//   clk, rst_n        clock, async active-low reset (all counters to 0)
//   inc_en/inc_idx    a writer leaves operand fetch for execute
//   dec_en/dec_idx    a writeback retires a pending write
//   rs1/rs2/rd_idx    lookup indices; *_cnt return the current counts
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int MAX_INFLIGHT = cpu_pkg::MAX_INFLIGHT,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  reg_idx_t         inc_idx,
  input  logic             dec_en,
  input  reg_idx_t         dec_idx,
  input  reg_idx_t         rs1_idx,
  input  reg_idx_t         rs2_idx,
  input  reg_idx_t         rd_idx,
  output logic [CNT_W-1:0] rs1_cnt,
  output logic [CNT_W-1:0] rs2_cnt,
  output logic [CNT_W-1:0] rd_cnt
);
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      // Increment and decrement on the same register cancel out.
      if (inc_en && inc_idx == reg_idx_t'(i) && !(dec_en && dec_idx == reg_idx_t'(i)))
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (dec_en && dec_idx == reg_idx_t'(i) && !(inc_en && inc_idx == reg_idx_t'(i)))
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign rs1_cnt = cnt_q[rs1_idx];
  assign rs2_cnt = cnt_q[rs2_idx];
  assign rd_cnt  = cnt_q[rd_idx];
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads two register-file ports, bypasses same-cycle
// writeback, stalls RAW hazards and full destination counters, and holds
// one output entry for execute.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_*                          decoded instruction (valid/ready)
//   rf_r_reg0/1, rf_r_dat0/1      combinational register-file read ports
//   wb_valid, wb_rd, wb_dat       writeback, same cycle as the RF write
//   flush                         drop the un-handed-off output entry
//   out_*                         operands to execute (valid/ready)
// XLEN must match cpu_pkg::XLEN since the output record uses the package width.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int XLEN         = cpu_pkg::XLEN,
  parameter int MAX_INFLIGHT = cpu_pkg::MAX_INFLIGHT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic            in_use_rs1,
  input  logic            in_use_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  output logic [4:0]      rf_r_reg0,
  output logic [4:0]      rf_r_reg1,
  input  logic [XLEN-1:0] rf_r_dat0,
  input  logic [XLEN-1:0] rf_r_dat1,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_dat,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op0,
  output logic [XLEN-1:0] out_op1,
  output logic [4:0]      out_rd,
  output logic            out_rd_we
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
  fetch_out_t       out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             wb_hit1, wb_hit2, wb_hit_rd;
  logic             haz1, haz2, dest_full, accept, out_hs;
  logic [XLEN-1:0]  op0_sel, op1_sel;

  assign rf_r_reg0 = in_rs1;
  assign rf_r_reg1 = in_rs2;

  assign wb_hit1   = wb_valid && wb_rd == in_rs1;
  assign wb_hit2   = wb_valid && wb_rd == in_rs2;
  assign wb_hit_rd = wb_valid && wb_rd == in_rd;

  assign op0_sel = (in_rs1 == '0) ? '0 : wb_hit1 ? wb_dat : rf_r_dat0;
  assign op1_sel = (in_rs2 == '0) ? '0 : wb_hit2 ? wb_dat : rf_r_dat1;

  // A single pending write retiring this cycle is covered by the bypass;
  // the writer sitting in the output stage is not counted yet, so check it.
  assign haz1 = in_use_rs1 && in_rs1 != '0 &&
                (rs1_cnt > CNT_W'(1) || (rs1_cnt == CNT_W'(1) && !wb_hit1) ||
                 (out_valid_q && out_q.rd_we && out_q.rd == in_rs1));
  assign haz2 = in_use_rs2 && in_rs2 != '0 &&
                (rs2_cnt > CNT_W'(1) || (rs2_cnt == CNT_W'(1) && !wb_hit2) ||
                 (out_valid_q && out_q.rd_we && out_q.rd == in_rs2));

  assign dest_full = in_rd_we && in_rd != '0 &&
                     rd_cnt == CNT_W'(MAX_INFLIGHT) && !wb_hit_rd;

  assign in_ready = !flush && (!out_valid_q || out_ready) && !haz1 && !haz2 && !dest_full;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  reg_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_en  (out_hs && out_q.rd_we),
    .inc_idx (out_q.rd),
    .dec_en  (wb_valid && wb_rd != '0),
    .dec_idx (wb_rd),
    .rs1_idx (in_rs1),
    .rs2_idx (in_rs2),
    .rd_idx  (in_rd),
    .rs1_cnt (rs1_cnt),
    .rs2_cnt (rs2_cnt),
    .rd_cnt  (rd_cnt)
  );

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_d.op0   = op0_sel;
      out_d.op1   = op1_sel;
      out_d.rd    = in_rd;
      out_d.rd_we = in_rd_we && in_rd != '0;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op0   = out_q.op0;
  assign out_op1   = out_q.op1;
  assign out_rd    = out_q.rd;
  assign out_rd_we = out_q.rd_we;
endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
  localparam int XLEN = 32;
  localparam int MAXF = 3;

  logic            clk, rst_n;
  logic            in_valid, in_ready, in_use_rs1, in_use_rs2, in_rd_we;
  logic [4:0]      in_rs1, in_rs2, in_rd, rf_r_reg0, rf_r_reg1, wb_rd, out_rd;
  logic [XLEN-1:0] rf_r_dat0, rf_r_dat1, wb_dat, out_op0, out_op1;
  logic            wb_valid, flush, out_valid, out_ready, out_rd_we;

  logic [XLEN-1:0] rf [32];
  int              mcnt [32];
  int              checks, failures;

  operand_fetch #(.XLEN(XLEN), .MAX_INFLIGHT(MAXF)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_r_reg0(rf_r_reg0), .rf_r_reg1(rf_r_reg1), .rf_r_dat0(rf_r_dat0), .rf_r_dat1(rf_r_dat1),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_dat(wb_dat), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op0(out_op0), .out_op1(out_op1),
    .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: combinational read, write alongside writeback.
  assign rf_r_dat0 = rf[rf_r_reg0];
  assign rf_r_dat1 = rf[rf_r_reg1];

  // Pending-write model used only to flag illegal stimulus.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
    end else begin
      if (wb_valid && wb_rd != 0) begin
        if (mcnt[wb_rd] == 0) begin
          $display("FAIL illegal_wb reg=%0d has no pending write", wb_rd);
          failures++;
        end
        rf[wb_rd] = wb_dat;
        mcnt[wb_rd] = mcnt[wb_rd] - 1;
      end
      if (out_valid && out_ready && out_rd_we) begin
        mcnt[out_rd] = mcnt[out_rd] + 1;
        if (mcnt[out_rd] > MAXF) begin
          $display("FAIL overflow reg=%0d count=%0d", out_rd, mcnt[out_rd]);
          failures++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_use_rs1 = 0; in_use_rs2 = 0; in_rs1 = 0; in_rs2 = 0;
    in_rd = 0; in_rd_we = 0; wb_valid = 0; wb_rd = 0; wb_dat = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we);
    in_valid = 1; in_rs1 = rs1; in_use_rs1 = u1; in_rs2 = rs2; in_use_rs2 = u2;
    in_rd = rd; in_rd_we = we;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [XLEN-1:0] d);
    wb_valid = 1; wb_rd = rd; wb_dat = d;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tick(); rst_n = 1; tick();
    // writer rd=3, then writer rd=6 back to back; rd=3 gets counted
    issue(0, 0, 0, 0, 3, 1); tick();
    issue(0, 0, 0, 0, 6, 1); tick();
    in_valid = 0; out_ready = 0;
    issue(3, 1, 0, 0, 0, 0); in_valid = 0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_pre_haz got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd6) begin failures++; $display("FAIL reset_pre_out got=%b/%0d exp=1/6", out_valid, out_rd); end
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_rd_we !== 1'b0) begin failures++; $display("FAIL reset_async got=%b/%0d/%b exp=0/0/0", out_valid, out_rd, out_rd_we); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_cnt_clear got=%b exp=1", in_ready); end
    tick(); rst_n = 1; out_ready = 1; tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_release got=%b/%b exp=1/0", in_ready, out_valid); end
    idle(); tick();
  endtask

  task automatic test_independent();
    idle();
    issue(2, 1, 0, 1, 0, 1);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL indep_ready got=%b exp=1", in_ready); end
    tick(); idle();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL indep_valid got=%b exp=1", out_valid); end
    checks++; if (out_op0 !== 32'd64 || out_op1 !== 32'd0) begin failures++; $display("FAIL indep_ops got=%h/%h exp=00000040/00000000", out_op0, out_op1); end
    checks++; if (out_rd_we !== 1'b0) begin failures++; $display("FAIL indep_rd0_we got=%b exp=0", out_rd_we); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL indep_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_raw_wb();
    idle();
    issue(0, 0, 0, 0, 5, 1); tick(); idle(); tick();   // handed off: cnt[5]=1
    issue(5, 1, 0, 0, 0, 0);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_stall got=%b exp=0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_stall2 got=%b exp=0", in_ready); end
    wb(5, 32'hDEADBEEF);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_wb_ready got=%b exp=1", in_ready); end
    tick(); idle();
    checks++; if (out_valid !== 1'b1 || out_op0 !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_bypass got=%b/%h exp=1/deadbeef", out_valid, out_op0); end
    in_rs1 = 5; in_use_rs1 = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_cnt_zero got=%b exp=1", in_ready); end
    idle(); tick();
  endtask

  task automatic test_out_stage();
    idle();
    issue(0, 0, 0, 0, 7, 1); tick();
    out_ready = 0;
    issue(0, 0, 7, 1, 0, 0);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ostage_stall got=%b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_rd_we !== 1'b1) begin failures++; $display("FAIL ostage_hold got=%b/%0d/%b exp=1/7/1", out_valid, out_rd, out_rd_we); end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ostage_uncounted got=%b exp=0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL ostage_counted got=%b/%b exp=0/0", in_ready, out_valid); end
    wb(7, 32'h77);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ostage_wb_ready got=%b exp=1", in_ready); end
    tick(); idle();
    checks++; if (out_op1 !== 32'h77 || out_op0 !== 32'd0) begin failures++; $display("FAIL ostage_op got=%h/%h exp=00000000/00000077", out_op0, out_op1); end
    tick();
  endtask

  task automatic test_saturation();
    idle();
    issue(0, 0, 0, 0, 9, 1); tick(); tick(); tick();   // three writers accepted
    in_valid = 0; tick();                              // third handed off: cnt[9]=3
    issue(0, 0, 0, 0, 9, 1);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL sat_stall got=%b exp=0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL sat_stall2 got=%b/%b exp=0/0", in_ready, out_valid); end
    wb(9, 32'h99);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL sat_wb_ready got=%b exp=1", in_ready); end
    tick(); idle();
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd9) begin failures++; $display("FAIL sat_accept got=%b/%0d exp=1/9", out_valid, out_rd); end
    tick();                                            // handoff: cnt[9] back to 3
    in_rd = 9; in_rd_we = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL sat_still_full got=%b exp=0", in_ready); end
    idle();
    for (int i = 0; i < 3; i++) begin wb(9, 32'h90 + i); tick(); end
    idle(); tick();
  endtask

  task automatic test_flush();
    idle();
    issue(0, 0, 0, 0, 4, 1); tick();
    in_valid = 0; out_ready = 0; flush = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got=%b exp=0", out_valid); end
    flush = 0; out_ready = 1;
    issue(4, 1, 0, 0, 0, 0);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_no_stall got=%b exp=1", in_ready); end
    tick(); idle();
    checks++; if (out_valid !== 1'b1 || out_op0 !== 32'd128) begin failures++; $display("FAIL flush_read got=%b/%h exp=1/00000080", out_valid, out_op0); end
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 32);
    idle();
    rst_n = 0;
    test_reset();
    test_independent();
    test_raw_wb();
    test_out_stage();
    test_saturation();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Requester side of the register file: drives its two combinational read ports and latches operands for the execute stage.
- Tracks in-flight register writes with a per-register pending counter and stalls read-after-write hazards.
- Bypasses the writeback value when the register file write lands in the same cycle as the read.
- Sits between decode and execute, with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, data width of operands and writeback data.
- MAX_INFLIGHT, 3, max outstanding writes per register; counter width is clog2(MAX_INFLIGHT+1).

Ports:
- clk  input  1  clock; all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  decoded instruction valid.
- in_ready  output  1  instruction accepted this cycle when high with in_valid.
- in_rs1, in_rs2  input  5  source register indices.
- in_use_rs1, in_use_rs2  input  1  source actually read.
- in_rd  input  5  destination index.
- in_rd_we  input  1  instruction writes in_rd.
- rf_r_reg0, rf_r_reg1  output  5  register file read addresses (= in_rs1, in_rs2, combinational).
- rf_r_dat0, rf_r_dat1  input  XLEN  register file read data (combinational).
- wb_valid  input  1  writeback this cycle (same cycle as register file write).
- wb_rd  input  5  writeback index.
- wb_dat  input  XLEN  writeback data.
- flush  input  1  drop un-handed-off output entry.
- out_valid  output  1  operands valid.
- out_ready  input  1  execute accepts.
- out_op0, out_op1  output  XLEN  operands.
- out_rd  output  5  destination index.
- out_rd_we  output  1  destination write enable.

Behaviour:
- Reset (async, rst_n low): all pending counters 0; out_valid 0; out_op0/out_op1/out_rd/out_rd_we 0. Takes effect immediately, including mid-stall.
- Operand select, per source rs:
  - rs==0 -> 0.
  - Else wb_valid && wb_rd==rs -> wb_dat.
  - Else rf_r_datN.
- Hazard(rs) when use && rs!=0 and any of:
  - cnt[rs] > 1;
  - cnt[rs]==1 and no wb hit on rs;
  - out_valid && out_rd_we && out_rd==rs (writer in the output stage is not yet counted).
- Dest-full stall: in_rd_we && in_rd!=0 && cnt[in_rd]==MAX_INFLIGHT && no wb decrement on in_rd this cycle.
- in_ready = !flush && (!out_valid || out_ready) && no hazard on either source && no dest-full stall. Combinational; no dependence on in_valid.
- Accept (in_valid && in_ready):
  - Output register loads selected operands, rd and rd_we (rd_we forced 0 when in_rd==0).
  - out_valid=1 next cycle; one-cycle latency.
- Output handshake (out_valid && out_ready, no accept): out_valid=0 next cycle.
- Output fields hold stable while out_valid && !out_ready.
- Counters:
  - Increment cnt[out_rd] at output handshake when out_rd_we.
  - Decrement cnt[wb_rd] on wb_valid && wb_rd!=0.
  - Increment and decrement on the same register in the same cycle -> unchanged.
- flush: out_valid=0 next cycle; counters untouched; no accept that cycle.
- Illegal, flagged by bench assertion and not handled in RTL: wb on a register with cnt 0; increment beyond MAX_INFLIGHT.
- Self-dependency (rs==rd of the same instruction): reads old value; no stall from itself.

Decomposition:
- Shared package cpu_pkg:
  - XLEN, REG_ADDR_W=5, NUM_REGS=32;
  - typedef reg_idx_t (logic [4:0]);
  - typedef fetch_out_t struct {op0, op1, rd, rd_we}.
- Sub-module reg_scoreboard: holds the 32 pending counters.
  - Inputs: inc_en, inc_idx, dec_en, dec_idx.
  - Outputs: per-index count lookup for rs1, rs2, rd.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> out_valid=0 immediately, all counters 0, in_ready=1 after release with out_valid=0.
- Independent read: register 2 holds 64, issue rs1=2, rs2=0 -> next cycle out_op0=64, out_op1=0, out_valid=1.
- RAW via writeback: writer rd=5 handed off; reader rs1=5 -> in_ready=0 until wb_valid, wb_rd=5, wb_dat=0xDEADBEEF; accepted that cycle with out_op0=0xDEADBEEF; cnt[5] returns to 0.
- Output-stage hazard: writer rd=7 held by out_ready=0; reader rs2=7 -> in_ready=0; after handoff still stalled until wb rd=7.
- Saturation: three writers rd=9 handed off, no wb -> fourth writer rd=9 stalls; wb rd=9 same cycle -> accepted, cnt[9] stays 3.
- Flush: out_valid=1 holding writer rd=4, flush=1 -> out_valid=0 next cycle, cnt[4]=0, reader rs1=4 proceeds without stall.
